// File: rtl/osd_mam_wb_slave_if.sv
// osd_mam_wb_slave_if
//   Wishbone B3 responder for the MAM debug master. Each classic or
//   incrementing-burst beat becomes one valid/ready request on the memory
//   port. Reads complete when the backend returns mem_rvalid.
//   Linear-burst address continuity is tracked between beats. A broken
//   burst, or an unsupported bte, ends the beat with err_o instead of
//   issuing a backend request.
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   cyc_i .. bte_i       Wishbone request (addr_i is a byte address)
//   ack_o, err_o, dat_o  Wishbone response (all registered)
//   mem_req_*            backend request: valid/ready, we, addr, wdata, be
//   mem_rvalid/rdata     backend read return, one pulse per read request
module osd_mam_wb_slave_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SW-1:0]         sel_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]         mem_be,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_e;

  state_e                state_q;
  logic                  ack_q, err_q, req_valid_q, we_q, in_burst_q;
  logic [DATA_WIDTH-1:0] dat_q, wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q, exp_addr_q;
  logic [SW-1:0]         be_q;
  logic [2:0]            cti_q;

  logic beat_err, complete;

  // Unsupported burst type, or a burst beat that does not continue the
  // previous beat's address.
  assign beat_err = ((cti_i == 3'b010) && (bte_i != 2'b00)) ||
                    (in_burst_q && (addr_i != exp_addr_q));

  // Backend transaction finishes: write accepted, or read data returned.
  // A read may return in the same cycle as it is accepted.
  assign complete = ((state_q == REQ) && mem_req_ready && (we_q || mem_rvalid)) ||
                    ((state_q == RWAIT) && mem_rvalid);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      dat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      exp_addr_q  <= '0;
      in_burst_q  <= 1'b0;
      cti_q       <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cyc_i) begin
            in_burst_q <= 1'b0;
          end else if (stb_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= dat_i;
            be_q    <= sel_i;
            cti_q   <= cti_i;
            if (beat_err) begin
              err_q      <= 1'b1;
              in_burst_q <= 1'b0;
              state_q    <= RESP;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          // Request stays up until accepted, even if the master abandons
          // the cycle.
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= RWAIT;
          end
        end
        RWAIT: ;
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Completion overrides the REQ->RWAIT move above.
      if (complete) begin
        if (!we_q) dat_q <= mem_rdata;
        if (cyc_i) begin
          ack_q      <= 1'b1;
          state_q    <= RESP;
          in_burst_q <= (cti_q == 3'b010);
          if (cti_q == 3'b010) exp_addr_q <= addr_q + ADDR_WIDTH'(SW);
        end else begin
          // Master left mid-beat: drop the ack silently.
          state_q <= IDLE;
        end
      end
    end
  end

  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign dat_o         = dat_q;
  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;

endmodule

// File: tb/tb_osd_mam_wb_slave_if.sv
module tb_osd_mam_wb_slave_if;
  logic        clk_i = 1'b0;
  logic        rst_i, cyc_i, stb_i, we_i;
  logic [31:0] addr_i;
  logic [15:0] dat_i;
  logic [1:0]  sel_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o, err_o;
  logic [15:0] dat_o;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;

  always #5 clk_i = ~clk_i;

  osd_mam_wb_slave_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .addr_i(addr_i), .dat_i(dat_i), .sel_i(sel_i), .cti_i(cti_i), .bte_i(bte_i),
    .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;

  // Backend memory (driven only by DUT requests) and reference memory
  // (updated from the beats the master issues).
  logic [7:0]  bk_mem [0:255];
  logic [7:0]  ref_mem[0:255];
  int          rdy_lat = 0, rv_lat = 0;
  int          req_cnt = 0, vld_cnt = 0;
  logic [31:0] last_req_addr = 0;

  // Reference beat-level state.
  bit          ref_in_burst = 0;
  logic [31:0] ref_exp = 0;
  logic [15:0] last_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backend responder: ready after rdy_lat cycles of valid, read data
  // rv_lat cycles after ready (0 = same cycle).
  initial begin : backend
    bit armed = 0, rv_pend = 0;
    int rcnt = 0, rv_cnt = 0;
    logic [15:0] rd_val = 0;
    logic [7:0]  idx;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk_i); #1;
      mem_req_ready = 0; mem_rvalid = 0;
      if (rv_pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = rd_val; rv_pend = 0; end
      end
      if (!mem_req_valid) armed = 0;
      else begin
        vld_cnt++;
        if (!armed) begin armed = 1; rcnt = rdy_lat; end
        if (rcnt == 0) begin
          mem_req_ready = 1; armed = 0; req_cnt++; last_req_addr = mem_addr;
          idx = mem_addr[7:0];
          if (mem_we) begin
            if (mem_be[0]) bk_mem[idx] = mem_wdata[7:0];
            if (mem_be[1]) bk_mem[idx + 8'd1] = mem_wdata[15:8];
          end else begin
            rd_val = {bk_mem[idx + 8'd1], bk_mem[idx]};
            if (rv_lat == 0) begin mem_rvalid = 1; mem_rdata = rd_val; end
            else begin rv_pend = 1; rv_cnt = rv_lat; end
          end
        end else rcnt--;
      end
    end
  end

  task automatic drive(input bit we, input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] s, input logic [2:0] cti, input logic [1:0] bte);
    cyc_i = 1; stb_i = 1; we_i = we; addr_i = a; dat_i = d; sel_i = s; cti_i = cti; bte_i = bte;
  endtask

  task automatic idle_cyc();
    cyc_i = 0; stb_i = 0;
    @(posedge clk_i); #1;
    ref_in_burst = 0;
  endtask

  // One Wishbone beat, checked against the reference rules. Called #1
  // after a clock edge.
  task automatic beat(input bit we, input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic [2:0] cti, input logic [1:0] bte,
                      input bit keep, input int rdy, input int rv);
    bit exp_err, got;
    int n, n0, v0, exp_lat;
    logic [7:0]  i0, i1;
    logic [15:0] exp_rd;
    i0 = a[7:0]; i1 = i0 + 8'd1;
    exp_err = ((cti == 3'b010) && (bte != 2'b00)) || (ref_in_burst && (a != ref_exp));
    exp_lat = exp_err ? 2 : (we ? 3 + rdy : 3 + rdy + rv);
    exp_rd  = {ref_mem[i1], ref_mem[i0]};
    rdy_lat = rdy; rv_lat = rv; n0 = req_cnt; v0 = vld_cnt;
    drive(we, a, d, s, cti, bte);
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(posedge clk_i); #1; n++;
      if (ack_o || err_o) got = 1;
    end
    chk("response_seen", {31'd0, got}, 1);
    chk("ack", {31'd0, ack_o}, {31'd0, !exp_err});
    chk("err", {31'd0, err_o}, {31'd0, exp_err});
    chk("latency", n + 1, exp_lat);   // cycles from stb-first cycle to response, inclusive
    if (!exp_err && !we) begin
      chk("rdata", {16'd0, dat_o}, {16'd0, exp_rd});
      last_rd = exp_rd;
    end else chk("dat_hold", {16'd0, dat_o}, {16'd0, last_rd});
    if (!exp_err && we) begin
      if (s[0]) ref_mem[i0] = d[7:0];
      if (s[1]) ref_mem[i1] = d[15:8];
    end
    if (exp_err) ref_in_burst = 0;
    else begin
      ref_in_burst = (cti == 3'b010);
      if (cti == 3'b010) ref_exp = a + 32'd2;
    end
    @(posedge clk_i); #1;
    chk("single_pulse", {31'd0, ack_o | err_o}, 0);
    chk("nreq", req_cnt - n0, exp_err ? 0 : 1);
    chk("valid_cycles", vld_cnt - v0, exp_err ? 0 : rdy + 1);
    if (!exp_err) chk("req_addr", last_req_addr, a);
    chk("in_burst", {31'd0, dut.in_burst_q}, {31'd0, ref_in_burst});
    if (!keep) idle_cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, {31'd0, ack_o}, 0);
    chk({tag, "_err"}, {31'd0, err_o}, 0);
    chk({tag, "_vld"}, {31'd0, mem_req_valid}, 0);
    chk({tag, "_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_dat"}, {16'd0, dat_o}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata}, 0);
    chk({tag, "_be"}, {30'd0, mem_be}, 0);
  endtask

  initial begin : main
    int n0, acks;
    logic [31:0] a;
    logic [2:0]  cti;
    for (int i = 0; i < 256; i++) begin
      bk_mem[i] = 8'(i) ^ 8'h5A; ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    bk_mem[8'h20] = 8'h34; bk_mem[8'h21] = 8'h12;
    ref_mem[8'h20] = 8'h34; ref_mem[8'h21] = 8'h12;
    rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; addr_i = 0; dat_i = 0;
    sel_i = 0; cti_i = 0; bte_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_vals("reset");
    rst_i = 0;
    @(posedge clk_i); #1;

    // Classic write, ready tied high: one valid cycle, ack in 3rd cycle.
    beat(1, 32'h100, 16'hBEEF, 2'b11, 3'b000, 2'b00, 0, 0, 0);
    // Classic read, ready after 2 cycles, rvalid 3 cycles later.
    beat(0, 32'h20, 16'h0, 2'b11, 3'b000, 2'b00, 0, 2, 3);
    chk("read_1234", {16'd0, last_rd}, 32'h1234);
    // Read back the written word with same-cycle rvalid.
    beat(0, 32'h100, 16'h0, 2'b11, 3'b000, 2'b00, 0, 1, 0);
    // 4-beat incrementing read.
    beat(0, 32'h40, 0, 2'b11, 3'b010, 2'b00, 1, 0, 1);
    beat(0, 32'h42, 0, 2'b11, 3'b010, 2'b00, 1, 1, 0);
    beat(0, 32'h44, 0, 2'b11, 3'b010, 2'b00, 1, 0, 2);
    beat(0, 32'h46, 0, 2'b11, 3'b111, 2'b00, 0, 0, 0);
    // Burst address mismatch: second beat errors, no request.
    beat(0, 32'h40, 0, 2'b11, 3'b010, 2'b00, 1, 0, 0);
    beat(0, 32'h48, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0);
    // Unsupported bte.
    beat(1, 32'h60, 16'h1111, 2'b11, 3'b010, 2'b01, 0, 0, 0);
    // Expected address wraps at the top of the address space.
    beat(1, 32'hFFFF_FFFE, 16'hA5C3, 2'b01, 3'b010, 2'b00, 1, 0, 0);
    beat(1, 32'h0000_0000, 16'h7E81, 2'b10, 3'b111, 2'b00, 0, 1, 0);

    // Abort: drop cyc while waiting for rvalid; no ack may follow.
    rdy_lat = 0; rv_lat = 5; n0 = req_cnt;
    drive(0, 32'h30, 0, 2'b11, 3'b000, 2'b00);
    repeat (2) @(posedge clk_i);
    #1;
    cyc_i = 0; stb_i = 0; acks = 0;
    repeat (8) begin @(posedge clk_i); #1; if (ack_o || err_o) acks++; end
    chk("abort_no_ack", acks, 0);
    chk("abort_nreq", req_cnt - n0, 1);
    ref_in_burst = 0;
    // FSM back in IDLE: a fresh read sees minimum latency.
    beat(0, 32'h30, 0, 2'b11, 3'b000, 2'b00, 0, 0, 0);

    // Reset while the request is held in REQ.
    rdy_lat = 10;
    drive(1, 32'h80, 16'hCAFE, 2'b11, 3'b000, 2'b00);
    repeat (2) @(posedge clk_i);
    #1;
    chk("req_held", {31'd0, mem_req_valid}, 1);
    rst_i = 1; cyc_i = 0; stb_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    chk_reset_vals("rst_req");
    last_rd = 0; ref_in_burst = 0;

    // Reset while awaiting rvalid: late rvalid is ignored in IDLE.
    rdy_lat = 0; rv_lat = 6;
    drive(0, 32'h20, 0, 2'b11, 3'b000, 2'b00);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1; cyc_i = 0; stb_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0; acks = 0;
    repeat (8) begin @(posedge clk_i); #1; if (ack_o || err_o) acks++; end
    chk("late_rvalid_no_ack", acks, 0);
    chk("late_rvalid_dat", {16'd0, dat_o}, 0);

    // Randomized beats and bursts.
    for (int k = 0; k < 80; k++) begin
      if (ref_in_burst && ($urandom % 8 != 0)) a = ref_exp;
      else a = ($urandom % 128) * 2;
      case ($urandom % 4)
        0: cti = 3'b000;
        3: cti = 3'b111;
        default: cti = 3'b010;
      endcase
      beat($urandom % 2, a, 16'($urandom), 2'($urandom_range(1, 3)), cti,
           ($urandom % 8 == 0) ? 2'b01 : 2'b00,
           (cti == 3'b010) ? ($urandom % 6 != 0) : ($urandom % 2 == 0),
           $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/osd_mam_wb_slave_if.md
Name: osd_mam_wb_slave_if

Overview:
- Wishbone B3 slave (responder) that terminates the bus cycles issued by the MAM Wishbone master.
- Converts classic and incrementing-burst cycles into a simple valid/ready memory request port plus a read-return port.
- Sits between the debug-side Wishbone bus and an on-chip SRAM or memory controller, and serves as the system-side target for MAM access.
- Checks burst address continuity and flags unsupported burst types with err_o.

Parameters:
- DATA_WIDTH, 16, data bus width in bits; allowed values 8/16/32.
- ADDR_WIDTH, 32, byte address width.
- SW, derived localparam, DATA_WIDTH/8; select/strobe width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- cyc_i  in  1  Wishbone cycle valid.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SW  byte select.
- cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst.
- bte_i  in  2  burst type; only 00 (linear) is supported.
- ack_o  out  1  beat acknowledge.
- err_o  out  1  beat error termination.
- dat_o  out  DATA_WIDTH  read data.
- mem_req_valid  out  1  backend request valid.
- mem_req_ready  in  1  backend accepts request.
- mem_we  out  1  backend write enable.
- mem_addr  out  ADDR_WIDTH  backend byte address.
- mem_wdata  out  DATA_WIDTH  backend write data.
- mem_be  out  SW  backend byte enables.
- mem_rvalid  in  1  read data return valid (one cycle per read request).
- mem_rdata  in  DATA_WIDTH  read return data.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE; ack_o, err_o, mem_req_valid, mem_we = 0; dat_o, mem_addr, mem_wdata, mem_be, exp_addr = 0; in_burst = 0.
- All outputs are registered.
- FSM states: IDLE, REQ, RWAIT, RESP.
- IDLE, on cyc_i & stb_i:
  - Capture we_i, addr_i, dat_i, sel_i, cti_i.
  - Error check. A beat is an error if bte_i != 00 while cti_i = 010. It is also an error if in_burst = 1 and addr_i != exp_addr.
  - On error: go to RESP with err_o = 1 next cycle; no backend request is issued.
  - Otherwise: go to REQ with mem_req_valid = 1 next cycle.
- REQ:
  - mem_req_valid, mem_we, mem_addr, mem_wdata and mem_be hold stable until mem_req_ready, regardless of cyc_i.
  - On a write with ready: go to RESP; ack_o = 1 next cycle.
  - On a read with ready: go to RWAIT.
  - mem_rvalid arriving in the same cycle as ready is legal. In that case capture mem_rdata and go straight to RESP.
- RWAIT: on mem_rvalid, dat_o <= mem_rdata and go to RESP with ack_o = 1.
- RESP:
  - ack_o or err_o is high for exactly this one cycle, then return to IDLE.
  - The master samples the ack at this edge and presents the next beat, which IDLE evaluates the following cycle.
  - Minimum beat latency: 3 cycles (stb sampled -> req -> ready -> ack).
- Burst tracking, updated when a beat is acked:
  - cti = 010: in_burst = 1, exp_addr = beat addr + SW (wraps modulo 2^ADDR_WIDTH).
  - cti = 000 or 111: in_burst = 0.
  - err_o: in_burst = 0.
  - cyc_i low in IDLE: in_burst = 0.
- Abort:
  - If cyc_i falls while in REQ or RWAIT, the backend transaction still completes (request held, rvalid awaited).
  - ack_o is suppressed if cyc_i = 0 at the completion cycle; go directly to IDLE.
- dat_o holds the last read data until the next read completes. For a write ack, dat_o is unchanged.
- Never ack_o and err_o in the same cycle.
- Never more than one outstanding backend request.
- Reset mid-operation: immediate return to the reset values. A pending backend rvalid arriving after reset is ignored in IDLE.

Test Plan:
- Classic write: cyc=stb=we=1, addr=0x100, dat=0xBEEF, sel=11, cti=000, mem_req_ready tied 1 -> mem_req_valid for 1 cycle with mem_addr=0x100, mem_wdata=0xBEEF, mem_be=11; ack_o is a single pulse 3 cycles after stb sampled.
- Classic read with backend latency: addr=0x20, ready after 2 cycles, rvalid 3 cycles after ready with rdata=0x1234 -> dat_o=0x1234 while ack_o=1; exactly one ack.
- 4-beat incrementing read: addrs 0x40/0x42/0x44/0x46, cti 010,010,010,111 -> 4 backend reads in order, 4 acks, in_burst=0 after the last beat.
- Burst address mismatch: beat 1 addr 0x40 cti 010, beat 2 addr 0x48 -> err_o pulse, no backend request for beat 2, in_burst cleared.
- Unsupported bte: cti=010, bte=01 -> err_o, no mem_req_valid.
- Abort and reset: drop cyc_i while waiting for rvalid -> no ack_o, FSM in IDLE after rvalid; assert rst_i in REQ -> mem_req_valid=0 next cycle, all outputs at reset values.
